// File: rtl/divmod_u_if.sv
// Operand/result handshake bundle for divmod_u; master = producer/consumer side, slave = divider side.
interface divmod_u_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             busy;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, busy
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, busy
  );
endinterface

// File: rtl/divmod_u.sv
// Iterative restoring unsigned divider: quotient, remainder and divide-by-zero flag.
// Latency WIDTH/BITS_PER_CYCLE cycles (1 for divisor==0); DIVMOD_EARLY_EXIT_EN skips leading zeros.
// Backpressure: one operation in flight, result held until out_ready; in_ready only when idle.
module divmod_u #(
  parameter int WIDTH          = 64,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  divmod_u_if.slave  io
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] dvd_nxt;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             out_valid_r;
  logic             dbz_r;
  logic             accept;
  logic             zero_dsr;
  logic             skip;
  logic [WIDTH-1:0] init_dvd;
  logic [CW-1:0]    init_cnt;

  assign accept   = io.in_valid && (state == IDLE);
  assign zero_dsr = (io.divisor == '0);

`ifdef DIVMOD_EARLY_EXIT_EN
  logic [CW-1:0] lz;
  logic [CW-1:0] lz_rnd;

  // Highest set bit wins; an all-zero dividend keeps lz = WIDTH.
  always_comb begin
    lz = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (io.dividend[i]) lz = CW'(WIDTH - 1 - i);
    end
  end

  assign lz_rnd   = lz & ~CW'(BITS_PER_CYCLE - 1);
  assign init_dvd = io.dividend << lz_rnd;
  assign init_cnt = (CW'(WIDTH) - lz_rnd) >> $clog2(BITS_PER_CYCLE);
  assign skip     = (io.dividend == '0);
`else
  assign init_dvd = io.dividend;
  assign init_cnt = CW'(WIDTH / BITS_PER_CYCLE);
  assign skip     = 1'b0;
`endif

  // trial carries one bit above rem so divisors >= 2^(WIDTH-1) never lose the shifted-out carry.
  always_comb begin
    rem_nxt = rem;
    quo_nxt = quo;
    dvd_nxt = dvd;
    trial   = '0;
    for (int s = 0; s < BITS_PER_CYCLE; s++) begin
      trial = {rem_nxt, dvd_nxt[WIDTH-1]};
      if (trial >= {1'b0, dsr}) begin
        rem_nxt = trial[WIDTH-1:0] - dsr;
        quo_nxt = {quo_nxt[WIDTH-2:0], 1'b1};
      end else begin
        rem_nxt = trial[WIDTH-1:0];
        quo_nxt = {quo_nxt[WIDTH-2:0], 1'b0};
      end
      dvd_nxt = dvd_nxt << 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (zero_dsr || skip) ? DONE : BUSY;
      BUSY: if (cnt == CW'(1)) state_nxt = DONE;
      DONE: if (out_valid_r && io.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem         <= '0;
      quo         <= '0;
      dvd         <= '0;
      dsr         <= '0;
      cnt         <= '0;
      quotient_r  <= '0;
      remainder_r <= '0;
      out_valid_r <= 1'b0;
      dbz_r       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rem <= '0;
            quo <= '0;
            dvd <= init_dvd;
            dsr <= io.divisor;
            cnt <= init_cnt;
            if (zero_dsr) begin
              quotient_r  <= '1;
              remainder_r <= io.dividend;
              dbz_r       <= 1'b1;
            end else if (skip) begin
              quotient_r  <= '0;
              remainder_r <= '0;
            end
          end
        end
        BUSY: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          dvd <= dvd_nxt;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            quotient_r  <= quo_nxt;
            remainder_r <= rem_nxt;
            out_valid_r <= 1'b1;
          end
        end
        DONE: begin
          // Short-cut results arrive here with out_valid low; raise it one cycle later.
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
          end else if (io.out_ready) begin
            out_valid_r <= 1'b0;
            dbz_r       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign io.in_ready    = (state == IDLE);
  assign io.busy        = (state == BUSY);
  assign io.out_valid   = out_valid_r;
  assign io.quotient    = quotient_r;
  assign io.remainder   = remainder_r;
  assign io.div_by_zero = dbz_r;
endmodule

// File: tb/tb_divmod_u.sv
// Directed bench for divmod_u: BITS_PER_CYCLE=1 and =4 instances, results and latency vs hand values.
module tb_divmod_u;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total = 0;
  int   lat;

  always #5 clk = ~clk;

  divmod_u_if #(.WIDTH(64)) io0 ();
  divmod_u_if #(.WIDTH(64)) io4 ();

  divmod_u #(.WIDTH(64), .BITS_PER_CYCLE(1)) u0 (.clk(clk), .rst_n(rst_n), .io(io0.slave));
  divmod_u #(.WIDTH(64), .BITS_PER_CYCLE(4)) u4 (.clk(clk), .rst_n(rst_n), .io(io4.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Latency per the behaviour description: fixed, or significant-bit based with early exit.
  function automatic int exp_lat(input logic [63:0] a, input logic [63:0] b, input int bpc);
    int sig;
    sig = 0;
    if (b == 64'd0) return 1;
`ifdef DIVMOD_EARLY_EXIT_EN
    for (int i = 0; i < 64; i++) if (a[i]) sig = i + 1;
    if (sig == 0) return 1;
    return (sig + bpc - 1) / bpc;
`else
    return 64 / bpc + sig;
`endif
  endfunction

  task automatic op0(input logic [63:0] a, input logic [63:0] b, output int l);
    io0.dividend = a;
    io0.divisor  = b;
    io0.in_valid = 1'b1;
    @(posedge clk); #1;
    io0.in_valid = 1'b0;
    io0.dividend = '1;
    io0.divisor  = 64'd1;
    l = 0;
    while (!io0.out_valid && l < 300) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic op4(input logic [63:0] a, input logic [63:0] b, output int l);
    io4.dividend = a;
    io4.divisor  = b;
    io4.in_valid = 1'b1;
    @(posedge clk); #1;
    io4.in_valid = 1'b0;
    io4.dividend = '0;
    l = 0;
    while (!io4.out_valid && l < 300) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  initial begin
    io0.in_valid = 1'b0; io0.dividend = '0; io0.divisor = '0; io0.out_ready = 1'b1;
    io4.in_valid = 1'b0; io4.dividend = '0; io4.divisor = '0; io4.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    chk("rst_in_ready", 64'(io0.in_ready), 64'd1);
    chk("rst_out_valid", 64'(io0.out_valid), 64'd0);
    chk("rst_busy", 64'(io0.busy), 64'd0);
    chk("rst_quotient", io0.quotient, 64'd0);
    chk("rst_remainder", io0.remainder, 64'd0);
    chk("rst_dbz", 64'(io0.div_by_zero), 64'd0);

    // 1000 / 7
    op0(64'd1000, 64'd7, lat);
    chk("t1_lat", 64'(lat), 64'(exp_lat(64'd1000, 64'd7, 1)));
    chk("t1_q", io0.quotient, 64'd142);
    chk("t1_r", io0.remainder, 64'd6);
    chk("t1_dbz", 64'(io0.div_by_zero), 64'd0);
    @(posedge clk); #1;
    chk("t1_ready_after", 64'(io0.in_ready), 64'd1);

    // Large divisor on the 4-bit/cycle instance
    op4(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, lat);
    chk("t2_lat", 64'(lat), 64'(exp_lat(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 4)));
    chk("t2_q", io4.quotient, 64'd1);
    chk("t2_r", io4.remainder, 64'h7FFF_FFFF_FFFF_FFFE);
    @(posedge clk); #1;
    op4(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, lat);
    chk("t2b_q", io4.quotient, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t2b_r", io4.remainder, 64'd0);
    @(posedge clk); #1;

    // Divide by zero, then a normal op clears the flag
    op0(64'h1234, 64'd0, lat);
    chk("t3_lat", 64'(lat), 64'd1);
    chk("t3_q", io0.quotient, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t3_r", io0.remainder, 64'h1234);
    chk("t3_dbz", 64'(io0.div_by_zero), 64'd1);
    @(posedge clk); #1;
    op0(64'd100, 64'd10, lat);
    chk("t3b_lat", 64'(lat), 64'(exp_lat(64'd100, 64'd10, 1)));
    chk("t3b_q", io0.quotient, 64'd10);
    chk("t3b_r", io0.remainder, 64'd0);
    chk("t3b_dbz", 64'(io0.div_by_zero), 64'd0);
    @(posedge clk); #1;

    // Divisor larger than dividend
    op0(64'd5, 64'd9, lat);
    chk("t3c_q", io0.quotient, 64'd0);
    chk("t3c_r", io0.remainder, 64'd5);
    @(posedge clk); #1;

    // Backpressure with ignored in_valid pulses
    io0.out_ready = 1'b0;
    op0(64'd48, 64'd18, lat);
    chk("t4_lat", 64'(lat), 64'(exp_lat(64'd48, 64'd18, 1)));
    for (int c = 0; c < 20; c++) begin
      io0.in_valid = (c % 2 == 0);
      io0.dividend = 64'd999;
      io0.divisor  = 64'd1;
      @(posedge clk); #1;
      chk("t4_vld_rdy", {62'd0, io0.out_valid, io0.in_ready}, 64'b10);
      chk("t4_q", io0.quotient, 64'd2);
      chk("t4_r", io0.remainder, 64'd12);
    end
    io0.in_valid  = 1'b0;
    io0.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t4_release_vld", 64'(io0.out_valid), 64'd0);
    chk("t4_release_rdy", 64'(io0.in_ready), 64'd1);
    chk("t4_hold_q", io0.quotient, 64'd2);
    @(posedge clk); #1;
    chk("t4_no_accept", {62'd0, io0.busy, io0.in_ready}, 64'b01);

    // Reset mid-operation
    io0.dividend = 64'hFFFF_FFFF_FFFF_FFF0;
    io0.divisor  = 64'd3;
    io0.in_valid = 1'b1;
    @(posedge clk); #1;
    io0.in_valid = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    chk("t5_busy_pre", 64'(io0.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_out_valid", 64'(io0.out_valid), 64'd0);
    chk("t5_busy", 64'(io0.busy), 64'd0);
    chk("t5_q", io0.quotient, 64'd0);
    chk("t5_r", io0.remainder, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t5_ready", 64'(io0.in_ready), 64'd1);
    op0(64'd81, 64'd9, lat);
    chk("t5b_lat", 64'(lat), 64'(exp_lat(64'd81, 64'd9, 1)));
    chk("t5b_q", io0.quotient, 64'd9);
    chk("t5b_r", io0.remainder, 64'd0);
    @(posedge clk); #1;

    // Small and zero dividends (short latency when early exit is built in)
    op0(64'd5, 64'd2, lat);
    chk("t6_lat", 64'(lat), 64'(exp_lat(64'd5, 64'd2, 1)));
    chk("t6_q", io0.quotient, 64'd2);
    chk("t6_r", io0.remainder, 64'd1);
    @(posedge clk); #1;
    op0(64'd0, 64'd3, lat);
    chk("t6b_lat", 64'(lat), 64'(exp_lat(64'd0, 64'd3, 1)));
    chk("t6b_q", io0.quotient, 64'd0);
    chk("t6b_r", io0.remainder, 64'd0);
    chk("t6b_dbz", 64'(io0.div_by_zero), 64'd0);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/divmod_u.md
Name: divmod_u

Overview:
- Parametrised iterative unsigned divider. Returns quotient and remainder of dividend / divisor.
- Successor to the single-output remainder unit used in the Euclidean (GCD) datapath. Adds:
  - a quotient output;
  - a configurable number of radix-2 steps per cycle;
  - valid/ready handshakes on both sides;
  - a divide-by-zero flag.
- Sits between the GCD control FSM and the AXI register front-end.

Parameters:
- WIDTH, 64: operand and result width in bits. Even, ≥ 4.
- BITS_PER_CYCLE, 1: restoring shift-subtract steps per clock. Legal values 1, 2 or 4, and must divide WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  unit idle and able to accept operands.
- dividend  in  WIDTH  numerator, sampled on the accept edge.
- divisor  in  WIDTH  denominator, sampled on the accept edge.
- out_valid  out  1  result valid; held until consumed.
- out_ready  in  1  consumer accepts the result.
- quotient  out  WIDTH  floor(dividend / divisor).
- remainder  out  WIDTH  dividend mod divisor.
- div_by_zero  out  1  set with a result produced from divisor == 0.
- busy  out  1  high in state BUSY.

Behaviour:
- Reset: clk and rst_n are fixed as stated. Asserting rst_n low clears immediately, regardless of clk:
  - state → IDLE;
  - out_valid, div_by_zero, busy → 0;
  - quotient, remainder, and all internal registers → 0;
  - in_ready → 1 once reset is released.
- A reset mid-operation discards the operation; no result is emitted.
- FSM states IDLE, BUSY, DONE. in_ready = (state == IDLE), combinational from state only.
- Accept: in_valid && in_ready at a rising edge. Operands are latched into internal copies; input changes afterwards have no effect.
  - divisor == 0 → go straight to DONE: quotient = all ones, remainder = dividend, div_by_zero = 1. out_valid rises 1 cycle after accept.
  - otherwise → go to BUSY with:
    - rem = 0 (WIDTH+1 bits);
    - quotient register = 0;
    - dvd = dividend;
    - cnt = WIDTH / BITS_PER_CYCLE.
- BUSY, each edge: perform BITS_PER_CYCLE chained restoring steps combinationally. Each step:
  - trial = {rem[WIDTH-1:0], dvd MSB};
  - q_bit = (trial ≥ divisor);
  - rem = q_bit ? trial − divisor : trial;
  - shift q_bit into the quotient LSB and shift dvd left by 1.
  - cnt decrements by 1 per edge.
  - The extra rem bit prevents carry loss when divisor ≥ 2^(WIDTH-1).
- Last iteration (cnt == 1): load quotient/remainder outputs, set out_valid = 1, go to DONE.
  - Latency from accept edge to out_valid high = WIDTH / BITS_PER_CYCLE cycles (64 for the defaults).
- DONE: outputs stable while out_valid = 1 and out_ready = 0.
  - On the edge where out_valid && out_ready: out_valid → 0, div_by_zero → 0, state → IDLE. in_ready is high the following cycle.
  - quotient/remainder keep their last values after the handshake.
- No back-to-back acceptance: a new operand can be accepted no earlier than the edge after the result handshake.
- in_valid while not in_ready: ignored. The upstream holds operands until accepted.
- out_ready while out_valid = 0: ignored.

Optional Feature:
- Macro: DIVMOD_EARLY_EXIT_EN.
- Defined:
  - On accept, compute lz = leading-zero count of dividend, rounded down to a multiple of BITS_PER_CYCLE.
  - Pre-shift dvd left by lz and set cnt = (WIDTH − lz) / BITS_PER_CYCLE.
  - dividend == 0 with a nonzero divisor → skip BUSY. Result quotient = 0, remainder = 0, out_valid 1 cycle after accept.
  - Resulting latency = max(1, ceil(significant_bits / BITS_PER_CYCLE)).
  - Results are identical to the non-early-exit build.
- Undefined: fixed latency of WIDTH / BITS_PER_CYCLE cycles; no leading-zero logic synthesised.

Test Plan:
1. WIDTH=64, BPC=1: dividend = 1000, divisor = 7, out_ready = 1 → out_valid 64 cycles after accept; quotient = 142, remainder = 6, div_by_zero = 0.
2. WIDTH=64, BPC=4: dividend = 2^64−1, divisor = 2^63+1 → quotient = 1, remainder = 2^63−2, latency 16 cycles.
3. Divisor = 0, dividend = 0x1234 → out_valid 1 cycle after accept; quotient = all ones, remainder = 0x1234, div_by_zero = 1. Next op (100 / 10) returns 10 / 0 with div_by_zero = 0.
4. Backpressure: dividend = 48, divisor = 18, out_ready held 0 for 20 cycles → out_valid, quotient = 2, remainder = 12 stable throughout; in_ready stays 0; in_valid pulses meanwhile are ignored. out_ready = 1 → in_ready = 1 next cycle.
5. Reset mid-operation: assert rst_n = 0 on iteration 30 → out_valid, busy, quotient, remainder = 0 immediately. After release, 81 / 9 → quotient = 9, remainder = 0.
6. DIVMOD_EARLY_EXIT_EN, BPC=1: dividend = 5, divisor = 2 → latency 3 cycles, quotient = 2, remainder = 1. dividend = 0, divisor = 3 → latency 1, results 0 / 0.
